// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
// SER_PARITY_EN adds the PARITY state used to append an even-parity bit.
package ser_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam logic        IdleLevel    = 1'b1;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } ser_state_e;
`else
    typedef enum logic {
        StIdle,
        StShift
    } ser_state_e;
`endif

endpackage

// File: rtl/ser_bit_cnt.sv
// Down-counter tracking the remaining data bits of the word being shifted out.
// Loads WIDTH-1 on acceptance and saturates at zero, where it flags the final bit.
module ser_bit_cnt
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CntW'(WIDTH - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready word intake and back-to-back streaming.
// Define SER_PARITY_EN to append an even-parity bit after each word's data bits.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             cnt_load, cnt_dec, cnt_last;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    ser_bit_cnt #(
        .WIDTH(WIDTH)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .dec (cnt_dec),
        .last(cnt_last)
    );

    // Outputs depend on registered state only, so data_ready never looks at data_valid.
    always_comb begin
        ser_out    = IdleLevel;
        ser_valid  = 1'b0;
        word_done  = 1'b0;
        data_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                data_ready = 1'b1;
            end
            StShift: begin
                ser_out   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
                ser_valid = 1'b1;
`ifndef SER_PARITY_EN
                word_done  = cnt_last;
                data_ready = cnt_last;
`endif
            end
`ifdef SER_PARITY_EN
            StParity: begin
                ser_out    = parity_q;
                ser_valid  = 1'b1;
                word_done  = 1'b1;
                data_ready = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign accept = data_valid & data_ready;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: ;
            StShift: begin
                if (!cnt_last) begin
                    cnt_dec = 1'b1;
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end
                end else begin
`ifdef SER_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef SER_PARITY_EN
            StParity: begin
                state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase

        // A new word overrides the return to idle, giving gap-free back-to-back words.
        if (accept) begin
            state_d  = StShift;
            sreg_d   = data_in;
            cnt_load = 1'b1;
`ifdef SER_PARITY_EN
            parity_d = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: fixed vectors, corner sequences and a
// random run against a queue-based model of the serial stream (MSB- and LSB-first).
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int L   = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int L   = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         m_ready, m_out, m_valid, m_done;
    logic         l_ready, l_out, l_valid, l_done;

    always #5 clk = ~clk;

    bit_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(1'b1)
    ) dut_m (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(m_ready),
        .ser_out   (m_out),
        .ser_valid (m_valid),
        .word_done (m_done)
    );

    bit_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(1'b0)
    ) dut_l (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(l_ready),
        .ser_out   (l_out),
        .ser_valid (l_valid),
        .word_done (l_done)
    );

    // Model: queue of symbols still to appear, head = symbol on the line now.
    typedef struct {
        bit b;
        bit last;
    } sym_t;

    sym_t qm[$];
    sym_t ql[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_word(input logic [W-1:0] d, input bit msb);
        sym_t s;
        for (int i = 0; i < W; i++) begin
            s.b    = msb ? d[W-1-i] : d[i];
            s.last = !PAR && (i == W - 1);
            if (msb) qm.push_back(s);
            else ql.push_back(s);
        end
        if (PAR) begin
            s.b    = ^d;
            s.last = 1'b1;
            if (msb) qm.push_back(s);
            else ql.push_back(s);
        end
    endfunction

    task automatic model_edge(input logic [W-1:0] d, input logic v, input logic r);
        bit   rdy_m, rdy_l;
        sym_t junk;
        rdy_m = (qm.size() <= 1);
        rdy_l = (ql.size() <= 1);
        if (r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) junk = qm.pop_front();
            if (ql.size() > 0) junk = ql.pop_front();
            if (v && rdy_m) push_word(d, 1'b1);
            if (v && rdy_l) push_word(d, 1'b0);
        end
    endtask

    task automatic check_models();
        bit e_o, e_v, e_d, e_r;
        e_v = (qm.size() > 0);
        e_o = e_v ? qm[0].b : 1'b1;
        e_d = e_v ? qm[0].last : 1'b0;
        e_r = (qm.size() <= 1);
        chk("model msb ser_out", m_out, e_o);
        chk("model msb ser_valid", m_valid, e_v);
        chk("model msb word_done", m_done, e_d);
        chk("model msb data_ready", m_ready, e_r);
        e_v = (ql.size() > 0);
        e_o = e_v ? ql[0].b : 1'b1;
        e_d = e_v ? ql[0].last : 1'b0;
        e_r = (ql.size() <= 1);
        chk("model lsb ser_out", l_out, e_o);
        chk("model lsb ser_valid", l_valid, e_v);
        chk("model lsb word_done", l_done, e_d);
        chk("model lsb data_ready", l_ready, e_r);
    endtask

    task automatic step(input logic [W-1:0] d, input logic v, input logic r);
        data_in    = d;
        data_valid = v;
        rst        = r;
        model_edge(d, v, r);
        @(posedge clk);
        #1;
        check_models();
    endtask

    typedef struct {
        logic [W-1:0] d;
        bit v, r, eo, eol, ev, ed, er;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] d, input bit v, input bit r, input bit eo,
                                input bit eol, input bit ev, input bit ed, input bit er);
        vec_t t;
        t.d = d; t.v = v; t.r = r; t.eo = eo; t.eol = eol; t.ev = ev; t.ed = ed; t.er = er;
        return t;
    endfunction

    // Two words: the second offered (with data_valid high) throughout the first;
    // with scramble, data_in wanders mid-word and settles on 'second' at the final edge.
    task automatic run_pair(input logic [W-1:0] first, input logic [W-1:0] second,
                            input bit scramble, input string name);
        logic [W-1:0] w[2];
        int           vcnt;
        int           dpos[$];
        logic [W-1:0] rd;
        int           k, j;
        w[0] = '0;
        w[1] = '0;
        vcnt = 0;
        for (int s = 1; s <= 2 * L; s++) begin
            rd = W'($urandom);
            if (s == 1) step(first, 1'b1, 1'b0);
            else if (s <= L) step(scramble ? rd : second, 1'b1, 1'b0);
            else if (s == L + 1) step(second, 1'b1, 1'b0);
            else step(rd, 1'b0, 1'b0);
            if (m_valid === 1'b1) vcnt++;
            if (m_done === 1'b1) dpos.push_back(s);
            k = (s - 1) / L;
            j = (s - 1) % L;
            if (j < W) w[k][W-1-j] = m_out;
        end
        step('0, 1'b0, 1'b0);
        chk({name, " valid cycles"}, vcnt, 2 * L);
        chk({name, " done count"}, dpos.size(), 2);
        if (dpos.size() == 2) begin
            chk({name, " first done pos"}, dpos[0], L);
            chk({name, " second done pos"}, dpos[1], 2 * L);
        end
        chk({name, " word0"}, w[0], first);
        chk({name, " word1"}, w[1], second);
        chk({name, " idle valid"}, m_valid, 1'b0);
        chk({name, " idle out"}, m_out, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[$];
        bit           em[8] = '{0, 0, 1, 1, 0, 1, 1, 0};
        bit           el[8] = '{0, 1, 1, 0, 1, 1, 0, 0};
        logic [W-1:0] rd;
        bit           rv, rr;

        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;

        // Accept 0x36 then idle; reset row first.
        tbl.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int i = 1; i <= 8; i++) begin
            tbl.push_back(mk(8'h36, i == 1, 1'b0, em[i-1], el[i-1], 1'b1,
                             !PAR && (i == 8), !PAR && (i == 8)));
        end
        if (PAR) tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].d, tbl[i].v, tbl[i].r);
            chk($sformatf("vec%0d msb ser_out", i), m_out, tbl[i].eo);
            chk($sformatf("vec%0d lsb ser_out", i), l_out, tbl[i].eol);
            chk($sformatf("vec%0d ser_valid", i), m_valid, tbl[i].ev);
            chk($sformatf("vec%0d word_done", i), m_done, tbl[i].ed);
            chk($sformatf("vec%0d data_ready", i), m_ready, tbl[i].er);
        end

`ifdef SER_PARITY_EN
        // 0x37 has odd weight, so the parity bit is 1.
        step(8'h37, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) step(8'h00, 1'b0, 1'b0);
        chk("parity 0x37 bit", m_out, 1'b1);
        chk("parity 0x37 done", m_done, 1'b1);
        step(8'h00, 1'b0, 1'b0);
`endif

        run_pair(8'h36, 8'h5A, 1'b0, "b2b");
        run_pair(8'h36, 8'hA5, 1'b1, "hold");

        // Reset while bit 3 of 0xFF is on the line, with a word offered during reset.
        step(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
        chk("rst mid valid before", m_valid, 1'b1);
        step(8'hAA, 1'b1, 1'b1);
        chk("rst mid ser_out", m_out, 1'b1);
        chk("rst mid ser_valid", m_valid, 1'b0);
        chk("rst mid data_ready", m_ready, 1'b1);
        chk("rst mid word_done", m_done, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("rst no resume valid", m_valid, 1'b0);
        chk("rst no resume done", m_done, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            rd = W'($urandom);
            rv = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 199) == 0);
            step(rd, rv, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
